// File: rtl/mem_arbiter_if.sv
// Master-side and memory-side signal bundle for mem_arbiter.
// The arbiter connects through the slave modport; the master modport is the mirror view.
interface mem_arbiter_if;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_we;
  logic        m0_re;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic        m1_re;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport slave (
    input  m0_addr, m0_wdata, m0_we, m0_re,
    input  m1_addr, m1_wdata, m1_we, m1_re,
    input  mem_rdata, mem_busy,
    output m0_rdata, m0_ack, m0_err,
    output m1_rdata, m1_ack, m1_err,
    output mem_addr, mem_wdata, mem_we, mem_re
  );

  modport master (
    output m0_addr, m0_wdata, m0_we, m0_re,
    output m1_addr, m1_wdata, m1_we, m1_re,
    output mem_rdata, mem_busy,
    input  m0_rdata, m0_ack, m0_err,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory bus between M0 (CPU) and M1 (DMA/debug).
// Optional WAIT-state abort is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        port_q, port_d;  // granted port: 0 = M0, 1 = M1
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        req0, req1, gnt;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  assign req0 = bus.m0_re | bus.m0_we;
  assign req1 = bus.m1_re | bus.m1_we;

  always_comb begin
    state_d  = state_q;
    port_d   = port_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Under contention the port that did not win last time gets the bus.
        gnt = (req0 && req1) ? ~last_q : req1;
        if (req0 || req1) begin
          port_d  = gnt;
          last_d  = gnt;
          we_d    = gnt ? bus.m1_we : bus.m0_we;
          addr_d  = gnt ? bus.m1_addr : bus.m0_addr;
          wdata_d = gnt ? bus.m1_wdata : bus.m0_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (!bus.mem_busy) begin
          if (!we_q) begin
            if (port_q) rdata1_d = bus.mem_rdata;
            else        rdata0_d = bus.mem_rdata;
          end
          state_d = DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          cnt_d = cnt_q + 16'd1;
          err_d = 1'b1;
          if (!we_q) begin
            if (port_q) rdata1_d = '0;
            else        rdata0_d = '0;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      port_q   <= port_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_re    = (state_q == ISSUE) && !we_q;
  assign bus.mem_we    = (state_q == ISSUE) && we_q;
  assign bus.m0_ack    = (state_q == DONE) && !port_q;
  assign bus.m1_ack    = (state_q == DONE) && port_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.m0_err    = (state_q == DONE) && !port_q && err_q;
  assign bus.m1_err    = (state_q == DONE) && port_q && err_q;
`else
  assign bus.m0_err    = 1'b0;
  assign bus.m1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a rule-level model predicts grant order, downstream
// accesses and per-port ack contents; a monitor pops and compares as the DUT responds.
module tb_mem_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dn_t;
  typedef struct { logic port; logic err; logic [31:0] rd0; logic [31:0] rd1; } ack_t;

  dn_t  dq[$];
  ack_t aq[$];
  int   lat_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acks = 0;
  int batch_start = 0;
  bit first_pending = 1'b0;
  int force_b = -1;
  bit stuck = 1'b0;
  bit model_abort = 1'b0;

  // reference model state
  logic        last_m = 1'b1;
  logic [31:0] exp_rd[2];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] dev_mem[logic [31:0]];

  // batch description: per port repeat count, strobes, address, data
  int          p_n[2];
  logic        p_re[2];
  logic        p_we[2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wd[2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %08h required %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rule-level prediction: round robin over outstanding per-port request counts.
  task automatic predict();
    int c[2];
    logic g;
    dn_t dn;
    ack_t ak;
    c[0] = p_n[0];
    c[1] = p_n[1];
    while (c[0] > 0 || c[1] > 0) begin
      if (c[0] > 0 && c[1] > 0) g = ~last_m;
      else g = (c[1] > 0);
      last_m = g;
      if (p_we[g]) ref_mem[p_addr[g]] = p_wd[g];
      else if (model_abort) exp_rd[g] = 32'h0;
      else exp_rd[g] = ref_mem.exists(p_addr[g]) ? ref_mem[p_addr[g]] : dflt(p_addr[g]);
      dn.we = p_we[g]; dn.addr = p_addr[g]; dn.wdata = p_wd[g];
      dq.push_back(dn);
      ak.port = g; ak.err = model_abort; ak.rd0 = exp_rd[0]; ak.rd1 = exp_rd[1];
      aq.push_back(ak);
      c[g] = c[g] - 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stuck = 1'b0;
    bus.m0_re = 0; bus.m0_we = 0; bus.m1_re = 0; bus.m1_we = 0;
    @(negedge clk);
    dq.delete(); aq.delete(); lat_q.delete();
    last_m = 1'b1; exp_rd[0] = 0; exp_rd[1] = 0;
    first_pending = 1'b0; model_abort = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_batch(input int bound, input bit expect_hang);
    int left0, left1;
    predict();
    @(negedge clk);
    left0 = p_n[0];
    left1 = p_n[1];
    bus.m0_re = (left0 > 0) && p_re[0]; bus.m0_we = (left0 > 0) && p_we[0];
    bus.m0_addr = p_addr[0]; bus.m0_wdata = p_wd[0];
    bus.m1_re = (left1 > 0) && p_re[1]; bus.m1_we = (left1 > 0) && p_we[1];
    bus.m1_addr = p_addr[1]; bus.m1_wdata = p_wd[1];
    batch_start = cyc;
    first_pending = 1'b1;
    for (int t = 0; t < bound && (left0 > 0 || left1 > 0); t++) begin
      @(negedge clk);
      if (bus.m0_ack && left0 > 0) begin
        left0--;
        if (left0 == 0) begin bus.m0_re = 0; bus.m0_we = 0; end
      end
      if (bus.m1_ack && left1 > 0) begin
        left1--;
        if (left1 == 0) begin bus.m1_re = 0; bus.m1_we = 0; end
      end
    end
    if (expect_hang) check("stuck_pending", 32'(left0 + left1), 32'(p_n[0] + p_n[1]));
    else if (left0 + left1 != 0) begin
      check("ack_timeout", 32'(left0 + left1), 32'd0);
      do_reset();
    end
  endtask

  // downstream memory responder
  initial begin
    int rem, b;
    logic [31:0] rdv;
    rem = 0; rdv = 0;
    bus.mem_busy = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rem = 0;
        bus.mem_busy = 1'b0;
      end else if (bus.mem_re || bus.mem_we) begin
        b = (force_b >= 0) ? force_b : int'($urandom_range(0, 4));
        if (bus.mem_we) begin
          dev_mem[bus.mem_addr] = bus.mem_wdata;
          rdv = $urandom;
        end else begin
          rdv = dev_mem.exists(bus.mem_addr) ? dev_mem[bus.mem_addr] : dflt(bus.mem_addr);
        end
        rem = b;
        bus.mem_busy = stuck;
        bus.mem_rdata = (b == 0 && !stuck) ? rdv : $urandom;
        if (stuck) begin
`ifdef MEM_ARB_TIMEOUT_EN
          lat_q.push_back(cyc + TMO + 1);
`endif
        end else begin
          lat_q.push_back(cyc + b + 2);
        end
      end else if (stuck) begin
        bus.mem_busy = 1'b1;
        bus.mem_rdata = $urandom;
      end else if (rem > 0) begin
        bus.mem_busy = 1'b1;
        bus.mem_rdata = $urandom;
        rem--;
      end else begin
        bus.mem_busy = 1'b0;
        bus.mem_rdata = rdv;
      end
    end
  end

  // monitor
  initial begin
    dn_t dn;
    ack_t ak;
    logic prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stb = 1'b0;
      end else begin
        if (bus.mem_re || bus.mem_we) begin
          if (prev_stb) check("strobe_width", 32'(prev_stb), 32'd0);
          if (first_pending) begin
            check("issue_latency", cyc, batch_start + 1);
            first_pending = 1'b0;
          end
          if (dq.size() == 0) check("unexpected_strobe", 32'(bus.mem_re | bus.mem_we), 32'd0);
          else begin
            dn = dq.pop_front();
            check("strobe_dir", {30'd0, bus.mem_we, bus.mem_re}, dn.we ? 32'd2 : 32'd1);
            check("mem_addr", bus.mem_addr, dn.addr);
            if (dn.we) check("mem_wdata", bus.mem_wdata, dn.wdata);
          end
        end
        prev_stb = bus.mem_re | bus.mem_we;
        if (bus.m0_ack || bus.m1_ack) begin
          n_acks++;
          check("dual_ack", 32'(bus.m0_ack & bus.m1_ack), 32'd0);
          if (aq.size() == 0) check("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
          else begin
            ak = aq.pop_front();
            check("ack_port", 32'(bus.m1_ack), 32'(ak.port));
            check("ack_err", {30'd0, bus.m1_err, bus.m0_err},
                  ak.err ? (ak.port ? 32'd2 : 32'd1) : 32'd0);
            check("m0_rdata", bus.m0_rdata, ak.rd0);
            check("m1_rdata", bus.m1_rdata, ak.rd1);
            if (lat_q.size() > 0) check("ack_latency", cyc, lat_q.pop_front());
          end
        end else if (bus.m0_err || bus.m1_err) begin
          check("err_without_ack", {30'd0, bus.m1_err, bus.m0_err}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, acks_before;
    bus.m0_re = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_re = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    exp_rd[0] = 0; exp_rd[1] = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_strobes_acks", {26'd0, bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err,
                               bus.mem_re, bus.mem_we}, 32'd0);
    check("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("rst_m1_rdata", bus.m1_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    // single FRAM read with three busy cycles
    ref_mem[32'h4010] = 32'hCAFE_F00D;
    dev_mem[32'h4010] = 32'hCAFE_F00D;
    force_b = 3;
    p_n[0] = 1; p_re[0] = 1; p_we[0] = 0; p_addr[0] = 32'h4010; p_wd[0] = 32'h0;
    p_n[1] = 0; p_re[1] = 0; p_we[1] = 0; p_addr[1] = 32'h0;    p_wd[1] = 32'h0;
    run_batch(100, 1'b0);

    // peripheral write from M1, no busy
    force_b = 0;
    p_n[0] = 0; p_re[0] = 0;
    p_n[1] = 1; p_we[1] = 1; p_re[1] = 0; p_addr[1] = 32'h0100; p_wd[1] = 32'h55;
    run_batch(100, 1'b0);

    // continuous contention, both reading
    force_b = -1;
    p_n[0] = 2; p_re[0] = 1; p_we[0] = 0; p_addr[0] = 32'h4010;
    p_n[1] = 2; p_re[1] = 1; p_we[1] = 0; p_addr[1] = 32'h0100;
    run_batch(200, 1'b0);

    // read and write together on M0: write wins
    p_n[0] = 1; p_re[0] = 1; p_we[0] = 1; p_addr[0] = 32'h4030; p_wd[0] = 32'h1234_5678;
    p_n[1] = 0; p_re[1] = 0; p_we[1] = 0;
    run_batch(100, 1'b0);

    // reset while in WAIT, then contention must favour M0
    force_b = 10;
    p_n[0] = 1; p_re[0] = 1; p_we[0] = 0; p_addr[0] = 32'h4020;
    predict();
    @(negedge clk);
    bus.m0_re = 1; bus.m0_addr = 32'h4020;
    batch_start = cyc; first_pending = 1'b1;
    repeat (4) @(negedge clk);
    do_reset();
    acks_before = n_acks;
    repeat (15) @(negedge clk);
    check("rst_mid_no_ack", 32'(n_acks), 32'(acks_before));
    check("rst_mid_rdata", bus.m0_rdata, 32'h0);
    force_b = -1;
    p_n[0] = 1; p_re[0] = 1; p_we[0] = 0; p_addr[0] = 32'h4010;
    p_n[1] = 1; p_re[1] = 1; p_we[1] = 0; p_addr[1] = 32'h0100;
    run_batch(200, 1'b0);

    // memory stuck busy
    stuck = 1'b1;
    p_n[0] = 1; p_re[0] = 1; p_we[0] = 0; p_addr[0] = 32'h4010;
    p_n[1] = 0; p_re[1] = 0; p_we[1] = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    model_abort = 1'b1;
    run_batch(60, 1'b0);
    model_abort = 1'b0;
    stuck = 1'b0;
    repeat (2) @(negedge clk);
`else
    acks_before = n_acks;
    run_batch(40, 1'b1);
    check("stuck_no_ack", 32'(n_acks), 32'(acks_before));
    check("stuck_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    do_reset();
`endif

    // randomized batches over a small address pool so reads hit earlier writes
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        p_n[p] = $urandom_range(0, 2);
        k = $urandom_range(0, 2);
        p_re[p] = (k != 1);
        p_we[p] = (k != 0);
        k = $urandom_range(0, 11);
        p_addr[p] = (k < 8) ? (32'h4000 + 32'(k * 4)) : (32'h0100 + 32'((k - 8) * 4));
        p_wd[p] = $urandom;
      end
      if (p_n[0] + p_n[1] == 0) p_n[$urandom_range(0, 1)] = 1;
      run_batch(400, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("leftover_acks", 32'(aq.size()), 32'd0);
    check("leftover_strobes", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
